// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone load/store master and its lane aligner.
package wb_master_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  // Unshifted lane masks; byte and half masks slide left by the address offset.
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/wb_lsu_align.sv
// Combinational lane logic for a 32-bit LSU: byte-select generation, store-lane
// replication, misalign/illegal-size detect, and load extract with sign/zero extension.
module wb_lsu_align
  import wb_master_pkg::*;
(
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_sel,
  output logic [31:0] req_lanes,
  output logic        req_bad,
  input  logic [1:0]  rsp_size,
  input  logic [1:0]  rsp_addr_lo,
  input  logic        rsp_unsigned,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rsp_rdata
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    req_sel   = '0;
    req_lanes = req_wdata;
    req_bad   = 1'b0;
    case (req_size)
      SIZE_BYTE: begin
        req_sel   = SEL_BYTE << req_addr_lo;
        req_lanes = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        req_bad   = req_addr_lo[0];
        req_sel   = req_addr_lo[0] ? 4'b0000 : (SEL_HALF << req_addr_lo);
        req_lanes = {2{req_wdata[15:0]}};
      end
      SIZE_WORD: begin
        req_bad = |req_addr_lo;
        req_sel = (|req_addr_lo) ? 4'b0000 : SEL_WORD;
      end
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    shifted   = bus_rdata >> {rsp_addr_lo, 3'b000};
    rsp_rdata = shifted;
    case (rsp_size)
      SIZE_BYTE: rsp_rdata = {{24{~rsp_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: rsp_rdata = {{16{~rsp_unsigned & shifted[15]}}, shifted[15:0]};
      default:   rsp_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/wishbone_lsu_master.sv
// Single-outstanding classic Wishbone initiator for the core's load/store path.
// Optional ACK watchdog is enabled by defining WB_MASTER_TIMEOUT_EN.
module wishbone_lsu_master
  import wb_master_pkg::*;
#(
  parameter int   DATA_WIDTH     = 32,
  parameter int   ADDR_WIDTH     = 32,
  parameter int   TIMEOUT_CYCLES = 16,
  parameter logic TAG_VALUE      = 1'b1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_REQ,
  input  logic                  i_WE,
  input  logic [1:0]            i_SIZE,
  input  logic                  i_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_WDATA,
  output logic                  o_READY,
  output logic                  o_DONE,
  output logic                  o_ERR,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_CYC,
  output logic                  o_STB,
  output logic                  o_WE,
  output logic [ADDR_WIDTH-1:0] o_ADDR,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic [3:0]            o_SEL,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  input  logic                  i_ACK,
  output logic                  o_TAGN,
  input  logic                  i_TAGN
);

  state_e      state, state_d;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        unsigned_q;
  logic        we_q;
  logic        err_q;
  logic        timeout_hit;
  logic        accept;
  logic        bus_end;

  logic [3:0]  req_sel;
  logic [31:0] req_lanes;
  logic        req_bad;
  logic [31:0] rsp_rdata;

  logic unused_tagn;
  assign unused_tagn = i_TAGN;
  assign o_TAGN      = TAG_VALUE;

  wb_lsu_align u_align (
    .req_size     (i_SIZE),
    .req_addr_lo  (i_ADDR[1:0]),
    .req_wdata    (i_WDATA),
    .req_sel      (req_sel),
    .req_lanes    (req_lanes),
    .req_bad      (req_bad),
    .rsp_size     (size_q),
    .rsp_addr_lo  (addr_lo_q),
    .rsp_unsigned (unsigned_q),
    .bus_rdata    (i_DATA),
    .rsp_rdata    (rsp_rdata)
  );

  assign accept  = (state == ST_IDLE) && i_REQ;
  assign bus_end = (state == ST_BUS) && (i_ACK || timeout_hit);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == ST_BUS && !i_ACK) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A late ACK in the final allowed cycle still completes normally.
  assign timeout_hit = (state == ST_BUS) && !i_ACK &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    o_READY = 1'b0;
    o_CYC   = 1'b0;
    o_DONE  = 1'b0;
    case (state)
      ST_IDLE: begin
        o_READY = 1'b1;
        if (i_REQ) state_d = req_bad ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        o_CYC = 1'b1;
        if (i_ACK || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        o_DONE  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_STB = o_CYC;
  assign o_ERR = o_DONE & err_q;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      size_q     <= SIZE_BYTE;
      addr_lo_q  <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      o_WE       <= 1'b0;
      o_ADDR     <= '0;
      o_DATA     <= '0;
      o_SEL      <= '0;
      o_RDATA    <= '0;
    end else begin
      if (accept) begin
        size_q     <= i_SIZE;
        addr_lo_q  <= i_ADDR[1:0];
        unsigned_q <= i_UNSIGNED;
        we_q       <= i_WE;
        err_q      <= req_bad;
        if (req_bad) begin
          o_RDATA <= '0;
        end else begin
          o_WE   <= i_WE;
          o_ADDR <= i_ADDR;
          o_DATA <= req_lanes;
          o_SEL  <= req_sel;
        end
      end
      if (bus_end) begin
        o_WE <= 1'b0;
        if (i_ACK) begin
          err_q <= 1'b0;
          if (!we_q) o_RDATA <= rsp_rdata;
        end else begin
          err_q   <= 1'b1;
          o_RDATA <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_lsu_master.sv
// Self-checking bench for wishbone_lsu_master: vector table through a scoreboard
// plus hand sequences for turnaround, error timing, reset-in-cycle and ACK watchdog.
module tb_wishbone_lsu_master;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err, cyc, stb, bwe, tag_o;
  logic [31:0] rdata, baddr, bdata;
  logic [3:0]  sel;
  logic [31:0] sdata = '0;
  logic        ack;
  logic        tag_i = 1'b0;

  always #5 clk = ~clk;

  wishbone_lsu_master #(.TIMEOUT_CYCLES(4)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_REQ(req), .i_WE(we), .i_SIZE(req_size),
    .i_UNSIGNED(uns), .i_ADDR(addr), .i_WDATA(wdata), .o_READY(ready),
    .o_DONE(done), .o_ERR(err), .o_RDATA(rdata), .o_CYC(cyc), .o_STB(stb),
    .o_WE(bwe), .o_ADDR(baddr), .o_DATA(bdata), .o_SEL(sel), .i_DATA(sdata),
    .i_ACK(ack), .o_TAGN(tag_o), .i_TAGN(tag_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          ack_at;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    int          exp_cycles;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[16];
  vec_t v;
  vec_t mon_e;
  int tests = 0;
  int fails = 0;

  // Slave model: ACK in the bus cycle whose index equals ack_at (-1 = never).
  int ack_at = 1;
  int bus_cyc = 0;
  assign ack = cyc && stb && (bus_cyc == ack_at);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   bus_cyc <= 0;
    else if (!cyc) bus_cyc <= 0;
    else          bus_cyc <= bus_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] sd, input logic e,
                              input logic [31:0] rd, input logic [3:0] sl,
                              input logic [31:0] bd);
    vec_t r;
    r.we = w; r.size = sz; r.uns = u; r.addr = a; r.wdata = wd; r.sdata = sd;
    r.ack_at = 1; r.exp_err = e; r.exp_rdata = rd; r.exp_sel = sl; r.exp_data = bd;
    r.exp_cycles = e ? 0 : 2;
    return r;
  endfunction

  // Monitor: counts bus cycles, captures bus fields on ACK, scores each DONE.
  int          cyc_cnt = 0;
  logic        done_prev = 1'b0;
  logic [3:0]  cap_sel = '0;
  logic [31:0] cap_addr = '0, cap_data = '0;
  logic        cap_we = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc_cnt   = 0;
      done_prev = 1'b0;
    end else begin
      if (cyc) cyc_cnt++;
      if (cyc && ack) begin
        cap_sel = sel; cap_addr = baddr; cap_data = bdata; cap_we = bwe;
      end
      if (done) begin
        check("done_single_cycle", 32'(done_prev), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("err", 32'(err), 32'(mon_e.exp_err));
          check("rdata", rdata, mon_e.exp_rdata);
          check("bus_cycles", 32'(cyc_cnt), 32'(mon_e.exp_cycles));
          if (!mon_e.exp_err) begin
            check("sel", 32'(cap_sel), 32'(mon_e.exp_sel));
            check("addr", cap_addr, mon_e.addr);
            check("we", 32'(cap_we), 32'(mon_e.we));
            if (mon_e.we) check("wdata_lanes", cap_data, mon_e.exp_data);
          end
        end
        cyc_cnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic drive_req(input vec_t r, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_wait", 32'd0, 32'd1);
    ack_at = r.ack_at; sdata = r.sdata;
    req = 1'b1; we = r.we; req_size = r.size; uns = r.uns; addr = r.addr; wdata = r.wdata;
    if (push) sb_q.push_back(r);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0 || !ready) begin
      check("done_wait", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_state();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(bwe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", baddr, 32'd0);
    check("rst_data", bdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("tagn", 32'(tag_o), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, SIZE_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
    vecs[1]  = mk(0, SIZE_BYTE, 0, 32'h13,  32'h0,        32'h80FFFF7F, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    vecs[2]  = mk(0, SIZE_BYTE, 1, 32'h13,  32'h0,        32'h80FFFF7F, 0, 32'h00000080, 4'b1000, 32'h0);
    vecs[3]  = mk(1, SIZE_HALF, 0, 32'h22,  32'h1234ABCD, 32'h0,        0, 32'h00000080, 4'b1100, 32'hABCDABCD);
    vecs[4]  = mk(0, SIZE_WORD, 0, 32'h06,  32'h0,        32'hFFFFFFFF, 1, 32'h0,        4'b0000, 32'h0);
    vecs[5]  = mk(1, SIZE_BYTE, 0, 32'h41,  32'h000000A5, 32'h0,        0, 32'h0,        4'b0010, 32'hA5A5A5A5);
    vecs[6]  = mk(0, SIZE_HALF, 0, 32'h02,  32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 4'b1100, 32'h0);
    vecs[7]  = mk(0, SIZE_HALF, 1, 32'h00,  32'h0,        32'h8001F00D, 0, 32'h0000F00D, 4'b0011, 32'h0);
    vecs[8]  = mk(0, SIZE_HALF, 0, 32'h01,  32'h0,        32'h12345678, 1, 32'h0,        4'b0000, 32'h0);
    vecs[9]  = mk(0, 2'b11,     0, 32'h00,  32'h0,        32'h12345678, 1, 32'h0,        4'b0000, 32'h0);
    vecs[10] = mk(1, SIZE_WORD, 0, 32'h100, 32'hCAFEF00D, 32'h0,        0, 32'h0,        4'b1111, 32'hCAFEF00D);
    vecs[11] = mk(0, SIZE_BYTE, 0, 32'h11,  32'h0,        32'h12345678, 0, 32'h00000056, 4'b0010, 32'h0);
    vecs[12] = mk(1, 2'b11,     0, 32'h03,  32'h0,        32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[13] = mk(0, SIZE_BYTE, 0, 32'h12,  32'h0,        32'h00C30000, 0, 32'hFFFFFFC3, 4'b0100, 32'h0);
    vecs[14] = mk(1, SIZE_WORD, 0, 32'h02,  32'h11111111, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[15] = mk(0, SIZE_BYTE, 1, 32'h00,  32'h0,        32'hFFFFFF7E, 0, 32'h0000007E, 4'b0001, 32'h0);

    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive_req(vecs[i], 1'b1);
      wait_idle();
    end

    // Zero-wait slave: 3-cycle accept-to-ready, requests outside IDLE ignored.
    v = mk(0, SIZE_WORD, 0, 32'h20, 32'h0, 32'h11223344, 0, 32'h11223344, 4'b1111, 32'h0);
    v.ack_at = 0; v.exp_cycles = 1;
    drive_req(v, 1'b1);
    check("zw_cyc", 32'(cyc), 32'd1);
    check("zw_stb", 32'(stb), 32'd1);
    check("zw_ready_bus", 32'(ready), 32'd0);
    req = 1'b1; we = 1'b1; req_size = SIZE_WORD; addr = 32'h40;
    @(posedge clk); #1;
    check("zw_done", 32'(done), 32'd1);
    check("zw_cyc_low", 32'(cyc), 32'd0);
    check("zw_ready_resp", 32'(ready), 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    check("zw_ready_back", 32'(ready), 32'd1);
    check("zw_done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("ignored_req_no_cycle", 32'(cyc), 32'd0);
    wait_idle();

    // Error path: completion in the cycle right after accept, no bus activity.
    v = mk(0, SIZE_WORD, 0, 32'h06, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    drive_req(v, 1'b1);
    check("errpath_done", 32'(done), 32'd1);
    check("errpath_err", 32'(err), 32'd1);
    check("errpath_cyc", 32'(cyc), 32'd0);
    wait_idle();

`ifdef WB_MASTER_TIMEOUT_EN
    v = mk(0, SIZE_WORD, 0, 32'h50, 32'h0, 32'h5555AAAA, 0, 32'h5555AAAA, 4'b1111, 32'h0);
    v.ack_at = 3; v.exp_cycles = 4;
    drive_req(v, 1'b1);
    wait_idle();
    v = mk(0, SIZE_WORD, 0, 32'h54, 32'h0, 32'h5555AAAA, 1, 32'h0, 4'b1111, 32'h0);
    v.ack_at = -1; v.exp_cycles = 4;
    drive_req(v, 1'b1);
    wait_idle();
`else
    v = mk(0, SIZE_WORD, 0, 32'h58, 32'h0, 32'h0BADF00D, 0, 32'h0BADF00D, 4'b1111, 32'h0);
    v.ack_at = 20; v.exp_cycles = 21;
    drive_req(v, 1'b1);
    wait_idle();
`endif

    // Reset asserted mid-cycle while the bus is active.
    v = mk(0, SIZE_WORD, 0, 32'h30, 32'h0, 32'h77777777, 0, 32'h0, 4'b1111, 32'h0);
    v.ack_at = -1;
    drive_req(v, 1'b0);
    req = 1'b1; addr = 32'h34;
    @(posedge clk); #1;
    req = 1'b0;
    check("bus_hold_cyc", 32'(cyc), 32'd1);
    check("bus_hold_addr", baddr, 32'h30);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", 32'(cyc), 32'd0);
    check("async_rst_stb", 32'(stb), 32'd0);
    check_reset_state();
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    v = mk(0, SIZE_BYTE, 1, 32'h31, 32'h0, 32'h0000AB00, 0, 32'h000000AB, 4'b0010, 32'h0);
    drive_req(v, 1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
